// File: rtl/a429_tx_sched.sv
// ARINC429 periodic transmit scheduler: per-slot ms timers, round-robin
// arbitration, single-entry FIFO-style read port toward the transmitter.
module a429_tx_sched #(
    parameter int CLOCK_KHZ = 100000,
    parameter int SLOTS     = 4,
    parameter int PW        = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_slot,
    input  logic             cfg_fld,
    input  logic [31:0]      cfg_dat,
    input  logic             sched_ena,
    input  logic [SLOTS-1:0] ovr_clr,
    input  logic             tf_rd,
    output logic [31:0]      tf_do,
    output logic             tf_et,
    output logic [2:0]       cur_slot,
    output logic [SLOTS-1:0] ovr_flg,
    output logic [SLOTS-1:0] pend_o
);

    localparam int PSW = (CLOCK_KHZ > 1) ? $clog2(CLOCK_KHZ) : 1;
    localparam logic [PSW-1:0] PS_LOAD = PSW'(CLOCK_KHZ - 1);

    typedef enum logic {IDLE, OFFER} state_t;

    state_t         state;
    logic [31:0]    word   [SLOTS];
    logic [PW-1:0]  period [SLOTS];
    logic [PW-1:0]  cnt    [SLOTS];
    logic [PSW-1:0] presc;
    logic [SLOTS-1:0] pend;
    logic [2:0]     last;

    logic             tick;
    logic [SLOTS-1:0] due;
    logic [SLOTS-1:0] wr_per;
    logic [SLOTS-1:0] wr_word;
    logic [SLOTS-1:0] rd_clr;
    logic             found;
    logic [2:0]       win;
    logic [31:0]      win_word;

    assign tick   = sched_ena && (presc == '0);
    assign pend_o = pend;

    // Out-of-range slot indices match no slot, so those writes drop out here.
    always_comb begin
        for (int s = 0; s < SLOTS; s++) begin
            wr_per[s]  = cfg_we && cfg_fld && (cfg_slot == 3'(s));
            wr_word[s] = cfg_we && !cfg_fld && (cfg_slot == 3'(s));
            due[s]     = tick && (period[s] != '0) && (cnt[s] == '0);
            rd_clr[s]  = (state == OFFER) && sched_ena && tf_rd
                         && (cur_slot == 3'(s));
        end
    end

    // Round-robin: scan last+1, last+2, ... modulo SLOTS.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        win_word = '0;
        for (int i = 1; i <= SLOTS; i++) begin
            for (int s = 0; s < SLOTS; s++) begin
                if (!found && pend[s]
                    && (((int'(last) + i) % SLOTS) == s)) begin
                    found = 1'b1;
                    win   = 3'(s);
                end
            end
        end
        for (int s = 0; s < SLOTS; s++) begin
            if (win == 3'(s)) win_word = word[s];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            presc    <= PS_LOAD;
            pend     <= '0;
            ovr_flg  <= '0;
            last     <= 3'(SLOTS - 1);
            state    <= IDLE;
            tf_do    <= '0;
            tf_et    <= 1'b1;
            cur_slot <= '0;
            for (int s = 0; s < SLOTS; s++) begin
                word[s]   <= '0;
                period[s] <= '0;
                cnt[s]    <= '0;
            end
        end else begin
            if (!sched_ena || presc == '0) presc <= PS_LOAD;
            else                           presc <= presc - 1'b1;

            for (int s = 0; s < SLOTS; s++) begin
                if (wr_word[s]) word[s] <= cfg_dat;
                if (ovr_clr[s]) ovr_flg[s] <= 1'b0;
                if (wr_per[s]) begin
                    period[s] <= cfg_dat[PW-1:0];
                    cnt[s]    <= '0;
                    pend[s]   <= 1'b0;
                end else if (!sched_ena) begin
                    pend[s] <= 1'b0;
                end else begin
                    if (tick && period[s] != '0) begin
                        if (cnt[s] == '0) cnt[s] <= period[s] - 1'b1;
                        else              cnt[s] <= cnt[s] - 1'b1;
                    end
                    // A new due event outranks both the read clear and ovr_clr.
                    if (due[s]) begin
                        pend[s] <= 1'b1;
                        if (pend[s] && !rd_clr[s]) ovr_flg[s] <= 1'b1;
                    end else if (rd_clr[s]) begin
                        pend[s] <= 1'b0;
                    end
                end
            end

            unique case (state)
                IDLE: begin
                    if (sched_ena && found) begin
                        tf_do    <= win_word;
                        cur_slot <= win;
                        tf_et    <= 1'b0;
                        state    <= OFFER;
                    end
                end
                OFFER: begin
                    if (!sched_ena) begin
                        tf_et <= 1'b1;
                        state <= IDLE;
                    end else if (tf_rd) begin
                        last  <= cur_slot;
                        tf_et <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a429_tx_sched.sv
// Self-checking bench for a429_tx_sched with a scoreboard of expected offers.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_a429_tx_sched;

    localparam int CK = 10;
    localparam int NS = 4;
    localparam int PW = 16;

    logic          clk       = 1'b0;
    logic          rst_i     = 1'b0;
    logic          cfg_we    = 1'b0;
    logic [2:0]    cfg_slot  = '0;
    logic          cfg_fld   = 1'b0;
    logic [31:0]   cfg_dat   = '0;
    logic          sched_ena = 1'b0;
    logic [NS-1:0] ovr_clr   = '0;
    logic          tf_rd     = 1'b0;
    logic [31:0]   tf_do;
    logic          tf_et;
    logic [2:0]    cur_slot;
    logic [NS-1:0] ovr_flg;
    logic [NS-1:0] pend_o;

    typedef struct packed {
        logic [2:0]  slot;
        logic [31:0] word;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    a429_tx_sched #(.CLOCK_KHZ(CK), .SLOTS(NS), .PW(PW)) dut (
        .clk_i(clk), .rst_i(rst_i), .cfg_we(cfg_we), .cfg_slot(cfg_slot),
        .cfg_fld(cfg_fld), .cfg_dat(cfg_dat), .sched_ena(sched_ena),
        .ovr_clr(ovr_clr), .tf_rd(tf_rd), .tf_do(tf_do), .tf_et(tf_et),
        .cur_slot(cur_slot), .ovr_flg(ovr_flg), .pend_o(pend_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic do_reset;
        rst_i = 1'b0;
        sched_ena = 1'b0;
        tf_rd = 1'b0;
        cfg_we = 1'b0;
        ovr_clr = '0;
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        @(negedge clk);
    endtask

    task automatic cfg_wr(input int slot, input logic fld, input logic [31:0] dat);
        @(negedge clk);
        cfg_we = 1'b1;
        cfg_slot = 3'(slot);
        cfg_fld = fld;
        cfg_dat = dat;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic push_exp(input int slot, input logic [31:0] w);
        exp_t e;
        e.slot = 3'(slot);
        e.word = w;
        exp_q.push_back(e);
    endtask

    task automatic wait_offer(output bit ok, input int budget);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (tf_et === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic pulse_rd;
        tf_rd = 1'b1;
        @(negedge clk);
        tf_rd = 1'b0;
    endtask

    task automatic test_reset;
        bit quiet;
        do_reset;
        checks++;
        if (tf_et !== 1'b1) begin
            errors++; $display("FAIL reset_et got=%0b want=1", tf_et);
        end
        checks++;
        if (tf_do !== 32'h0) begin
            errors++; $display("FAIL reset_do got=%h want=0", tf_do);
        end
        checks++;
        if (cur_slot !== 3'd0) begin
            errors++; $display("FAIL reset_slot got=%0d want=0", cur_slot);
        end
        checks++;
        if (ovr_flg !== '0 || pend_o !== '0) begin
            errors++;
            $display("FAIL reset_flags ovr=%b pend=%b want=0", ovr_flg, pend_o);
        end
        // Writes to a non-existent slot must not arm anything.
        cfg_wr(5, 1'b0, 32'hDEAD);
        cfg_wr(5, 1'b1, 32'h1);
        sched_ena = 1'b1;
        quiet = 1'b1;
        repeat (25) begin
            @(negedge clk);
            if (tf_et !== 1'b1 || pend_o !== '0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++; $display("FAIL bad_slot_write got=offer want=none");
        end
        sched_ena = 1'b0;
    endtask

    task automatic test_periodic;
        bit   ok;
        int   t_prev;
        int   want;
        exp_t e;
        do_reset;
        cfg_wr(0, 1'b0, 32'hA5);
        cfg_wr(0, 1'b1, 32'd2);
        for (int k = 0; k < 3; k++) push_exp(0, 32'hA5);
        @(negedge clk);
        sched_ena = 1'b1;
        t_prev = cyc;
        for (int k = 0; k < 3; k++) begin
            wait_offer(ok, 40);
            want = (k == 0) ? 11 : 20;
            checks++;
            if (!ok || (cyc - t_prev) != want) begin
                errors++;
                $display("FAIL periodic_gap%0d got=%0d want=%0d ok=%0b",
                         k, cyc - t_prev, want, ok);
            end
            t_prev = cyc;
            e = exp_q.pop_front();
            checks++;
            if (tf_do !== e.word || cur_slot !== e.slot) begin
                errors++;
                $display("FAIL periodic_word%0d got=%h/%0d want=%h/%0d",
                         k, tf_do, cur_slot, e.word, e.slot);
            end
            pulse_rd;
        end
        sched_ena = 1'b0;
    endtask

    task automatic test_round_robin;
        bit   ok;
        exp_t e;
        do_reset;
        for (int s = 0; s < NS; s++) begin
            cfg_wr(s, 1'b0, 32'h100 + 32'(s));
            cfg_wr(s, 1'b1, 32'd1);
        end
        for (int k = 0; k < 8; k++) push_exp(k % NS, 32'h100 + 32'(k % NS));
        @(negedge clk);
        sched_ena = 1'b1;
        tf_rd = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wait_offer(ok, 30);
            e = exp_q.pop_front();
            checks++;
            if (!ok || tf_do !== e.word || cur_slot !== e.slot) begin
                errors++;
                $display("FAIL rr_order%0d got=%h/%0d want=%h/%0d ok=%0b",
                         k, tf_do, cur_slot, e.word, e.slot, ok);
            end
        end
        @(negedge clk);
        tf_rd = 1'b0;
        checks++;
        if (ovr_flg !== '0) begin
            errors++; $display("FAIL rr_no_ovr got=%b want=0", ovr_flg);
        end
        sched_ena = 1'b0;
    endtask

    task automatic test_overrun;
        int   c;
        exp_t e;
        do_reset;
        cfg_wr(1, 1'b0, 32'h5A5A);
        cfg_wr(1, 1'b1, 32'd1);
        push_exp(1, 32'h5A5A);
        @(negedge clk);
        sched_ena = 1'b1;
        c = cyc;
        wait_until(c + 15);
        checks++;
        if (ovr_flg !== 4'b0000 || tf_et !== 1'b0) begin
            errors++;
            $display("FAIL ovr_first_tick ovr=%b et=%0b want=0000/0", ovr_flg, tf_et);
        end
        wait_until(c + 25);
        checks++;
        if (ovr_flg !== 4'b0010) begin
            errors++; $display("FAIL ovr_set got=%b want=0010", ovr_flg);
        end
        ovr_clr = 4'b0010;
        @(negedge clk);
        ovr_clr = '0;
        checks++;
        if (ovr_flg !== 4'b0000) begin
            errors++; $display("FAIL ovr_clear got=%b want=0000", ovr_flg);
        end
        // Clear lands on the same edge as the next overrun: the overrun wins.
        wait_until(c + 29);
        ovr_clr = 4'b0010;
        @(negedge clk);
        ovr_clr = '0;
        checks++;
        if (ovr_flg !== 4'b0010) begin
            errors++; $display("FAIL ovr_clr_race got=%b want=0010", ovr_flg);
        end
        e = exp_q.pop_front();
        checks++;
        if (tf_et !== 1'b0 || tf_do !== e.word || cur_slot !== e.slot) begin
            errors++;
            $display("FAIL ovr_word got=%0b/%h/%0d want=0/%h/%0d",
                     tf_et, tf_do, cur_slot, e.word, e.slot);
        end
        sched_ena = 1'b0;
    endtask

    task automatic test_word_update;
        bit   ok;
        exp_t e;
        do_reset;
        cfg_wr(2, 1'b0, 32'h11);
        cfg_wr(2, 1'b1, 32'd1);
        push_exp(2, 32'h11);
        @(negedge clk);
        sched_ena = 1'b1;
        wait_offer(ok, 20);
        e = exp_q.pop_front();
        checks++;
        if (!ok || tf_do !== e.word || cur_slot !== e.slot) begin
            errors++;
            $display("FAIL upd_first got=%h/%0d want=%h/%0d ok=%0b",
                     tf_do, cur_slot, e.word, e.slot, ok);
        end
        cfg_wr(2, 1'b0, 32'h22);
        push_exp(2, 32'h22);
        checks++;
        if (tf_et !== 1'b0 || tf_do !== 32'h11) begin
            errors++;
            $display("FAIL upd_stable got=%0b/%h want=0/00000011", tf_et, tf_do);
        end
        pulse_rd;
        checks++;
        if (tf_et !== 1'b1) begin
            errors++; $display("FAIL upd_consume got=%0b want=1", tf_et);
        end
        wait_offer(ok, 20);
        e = exp_q.pop_front();
        checks++;
        if (!ok || tf_do !== e.word || cur_slot !== e.slot) begin
            errors++;
            $display("FAIL upd_next got=%h/%0d want=%h/%0d ok=%0b",
                     tf_do, cur_slot, e.word, e.slot, ok);
        end
        pulse_rd;
        sched_ena = 1'b0;
    endtask

    task automatic test_disable;
        bit   ok;
        int   c;
        exp_t e;
        do_reset;
        cfg_wr(0, 1'b0, 32'h77);
        cfg_wr(0, 1'b1, 32'd1);
        @(negedge clk);
        sched_ena = 1'b1;
        wait_offer(ok, 20);
        checks++;
        if (!ok) begin
            errors++; $display("FAIL dis_pre got=no_offer want=offer");
        end
        sched_ena = 1'b0;
        tf_rd = 1'b1;
        @(negedge clk);
        tf_rd = 1'b0;
        checks++;
        if (tf_et !== 1'b1 || pend_o !== '0) begin
            errors++;
            $display("FAIL dis_withdraw et=%0b pend=%b want=1/0000", tf_et, pend_o);
        end
        @(negedge clk);
        sched_ena = 1'b1;
        c = cyc;
        push_exp(0, 32'h77);
        wait_offer(ok, 30);
        checks++;
        if (!ok || (cyc - c) != 11) begin
            errors++;
            $display("FAIL dis_reenable got=%0d want=11 ok=%0b", cyc - c, ok);
        end
        e = exp_q.pop_front();
        checks++;
        if (tf_do !== e.word || cur_slot !== e.slot) begin
            errors++;
            $display("FAIL dis_word got=%h/%0d want=%h/%0d",
                     tf_do, cur_slot, e.word, e.slot);
        end
        pulse_rd;
        sched_ena = 1'b0;
    endtask

    task automatic test_async_reset;
        bit   ok;
        bit   quiet;
        int   c;
        exp_t e;
        do_reset;
        cfg_wr(1, 1'b0, 32'h99);
        cfg_wr(1, 1'b1, 32'd1);
        @(negedge clk);
        sched_ena = 1'b1;
        c = cyc;
        wait_until(c + 21);
        checks++;
        if (tf_et !== 1'b0 || ovr_flg !== 4'b0010) begin
            errors++;
            $display("FAIL ar_pre et=%0b ovr=%b want=0/0010", tf_et, ovr_flg);
        end
        #2 rst_i = 1'b0;
        #1;
        checks++;
        if (tf_et !== 1'b1 || ovr_flg !== '0 || pend_o !== '0
            || tf_do !== 32'h0 || cur_slot !== 3'd0) begin
            errors++;
            $display("FAIL ar_async et=%0b ovr=%b pend=%b do=%h slot=%0d want=1/0/0/0/0",
                     tf_et, ovr_flg, pend_o, tf_do, cur_slot);
        end
        @(negedge clk);
        rst_i = 1'b1;
        quiet = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (tf_et !== 1'b1 || pend_o !== '0) quiet = 1'b0;
        end
        checks++;
        if (!quiet) begin
            errors++; $display("FAIL ar_quiet got=offer want=none");
        end
        cfg_wr(3, 1'b0, 32'h33);
        cfg_wr(3, 1'b1, 32'd1);
        push_exp(3, 32'h33);
        wait_offer(ok, 30);
        e = exp_q.pop_front();
        checks++;
        if (!ok || tf_do !== e.word || cur_slot !== e.slot) begin
            errors++;
            $display("FAIL ar_reprog got=%h/%0d want=%h/%0d ok=%0b",
                     tf_do, cur_slot, e.word, e.slot, ok);
        end
        pulse_rd;
        sched_ena = 1'b0;
    endtask

    initial begin
        test_reset;
        test_periodic;
        test_round_robin;
        test_overrun;
        test_word_update;
        test_disable;
        test_async_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
